stream_rr_arbiter: RTL

- Shares one valid/ready stream sink between `NUM_INPUTS` requesters using round-robin arbitration. Typical sink: a zero-latency queue.
- The output is combinational from the granted input, with zero added latency. Arbitration state and the priority pointer are registered.
- Grant is held while the sink back-pressures, and optionally for a whole packet (`in_last`-delimited).

---
 rtl/stream_arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/stream_rr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for stream_rr_arbiter.
//   arb_state_t : arbitration state (IDLE / HOLD / LOCKED)
//   rr_next     : wrapping increment of a requester index
package stream_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // free: grant is picked combinationally each cycle
    HOLD   = 2'd1,  // a stalled beat is pending; grant frozen until it moves
    LOCKED = 2'd2   // mid-packet; grant frozen until the in_last beat moves
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of req, searching upward
// from ptr and wrapping past NUM_INPUTS-1 back to 0.
//   req   : request vector
//   ptr   : search start position
//   found : any request set
//   index : winning position (ptr when nothing is found)
module rr_priority_pick #(
  parameter int NUM_INPUTS = 4,
  parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [ID_WIDTH-1:0]   ptr,
  output logic                  found,
  output logic [ID_WIDTH-1:0]   index
);

  logic [2*NUM_INPUTS-1:0] req_dbl;
  logic [2*NUM_INPUTS-1:0] req_rot;

  // Doubling the vector turns the cyclic search into a linear one:
  // req_rot[k] == req[(ptr + k) mod NUM_INPUTS] for k < NUM_INPUTS.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr;

  always_comb begin
    found = 1'b0;
    index = ptr;
    // Descending scan so the lowest offset is the last (winning) write.
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        index = ID_WIDTH'((int'(ptr) + k) % NUM_INPUTS);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between NUM_INPUTS
// requesters. Output path is combinational from the granted input; only the
// arbitration state, held grant and priority pointer are registered.
// Optional packet lock (grant held until the in_last beat) is built when
// STREAM_ARB_PACKET_LOCK_EN is defined; otherwise arbitration is per beat.
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready : requester streams (data packed by index)
//   out_valid/out_data/out_last/out_id/out_ready : shared sink stream
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [ID_WIDTH-1:0]              out_id,
  input  logic                             out_ready
);

  arb_state_t                          state_q, state_d;
  logic [ID_WIDTH-1:0]                 grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                                pick_found;
  logic [ID_WIDTH-1:0]                 pick_idx;
  logic [ID_WIDTH-1:0]                 grant;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_arr;
  logic                                xfer;
  logic                                lock_next;

  assign data_arr = in_data;

  rr_priority_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .ID_WIDTH   (ID_WIDTH)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  // Grant mux and ready decode.
  always_comb begin
    grant     = (state_q == IDLE) ? pick_idx : grant_id_q;
    out_valid = !reset && in_valid[grant];
    out_data  = data_arr[grant];
    out_last  = in_last[grant];
    out_id    = reset ? '0 : grant;
    in_ready  = '0;
    // Idle with nobody requesting: grant only names rr_ptr, nobody is ready.
    if (!reset && !(state_q == IDLE && !pick_found))
      in_ready[grant] = out_ready;
    xfer = out_valid && out_ready;
  end

`ifdef STREAM_ARB_PACKET_LOCK_EN
  assign lock_next = !out_last;
`else
  assign lock_next = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = ID_WIDTH'(rr_next(32'(grant), NUM_INPUTS));
      if (lock_next) begin
        state_d    = LOCKED;
        grant_id_d = grant;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // Stalled beat: freeze the grant so it is never re-arbitrated.
          if (out_valid) begin
            state_d    = HOLD;
            grant_id_d = grant;
          end
        end
        HOLD: begin
          // Requester withdrew its pending beat; release the sink.
          if (!in_valid[grant_id_q]) state_d = IDLE;
        end
        LOCKED: ;  // gaps inside a packet keep the lock
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule
